// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches to instruction
// memory, buffers returned words for decode and squashes wrong-path fetches on redirect.

module fetch_unit_chk #(
   parameter int DEPTH = 2,
   parameter int CW    = 2
) (
   input logic          clk,
   input logic          rst_n,
   input logic          imem_rvalid,
   input logic [CW-1:0] outstanding,
   input logic [CW-1:0] occupancy
);
   rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> (outstanding != '0));
   credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (int'(outstanding) + int'(occupancy)) <= DEPTH);
endmodule

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   input  logic        if_ready
);
   localparam int          CW  = $clog2(DEPTH + 1);
   localparam int          SW  = CW + 1;
   localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetch_pc_r;
   logic [31:0]   pcq_mem_r  [DEPTH];
   logic [PW-1:0] pcq_head_r;
   logic [PW-1:0] pcq_tail_r;
   logic [31:0]   buf_pc_r   [DEPTH];
   logic [31:0]   buf_inst_r [DEPTH];
   logic [PW-1:0] buf_head_r;
   logic [PW-1:0] buf_tail_r;
   logic [CW-1:0] outstanding_r;
   logic [CW-1:0] occupancy_r;
   logic [CW-1:0] discard_r;
   logic          run_r;
   logic          credit_s;
   logic          grant_s;
   logic          rsp_s;
   logic          push_s;
   logic          pop_s;
   logic          unused_bits_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] n;
      if (p == PW'(DEPTH - 1)) n = '0;
      else n = p + PW'(1);
      return n;
   endfunction

   // Handshake qualifiers and decode-facing view of the buffer head.
   always_comb begin
      credit_s  = ({1'b0, outstanding_r} + {1'b0, occupancy_r}) < SW'(DEPTH);
      imem_req  = run_r && !redirect_valid && credit_s;
      imem_addr = fetch_pc_r;
      if_valid  = (occupancy_r != '0) && !redirect_valid;
      if_inst   = NOP;
      if_pc     = 32'h0000_0000;
      if (occupancy_r != '0) begin
         if_inst = buf_inst_r[buf_head_r];
         if_pc   = buf_pc_r[buf_head_r];
      end else begin
         if_inst = NOP;
         if_pc   = 32'h0000_0000;
      end
      grant_s = imem_req && imem_gnt;
      rsp_s   = imem_rvalid && (outstanding_r != '0);
      push_s  = rsp_s && (discard_r == '0) && !redirect_valid;
      pop_s   = if_valid && if_ready;
   end

   assign unused_bits_s = ^redirect_pc[1:0];

   // PC, queue pointers, credit and discard bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_r    <= RESET_PC;
         pcq_head_r    <= '0;
         pcq_tail_r    <= '0;
         buf_head_r    <= '0;
         buf_tail_r    <= '0;
         outstanding_r <= '0;
         occupancy_r   <= '0;
         discard_r     <= '0;
         run_r         <= 1'b0;
      end else begin
         run_r <= 1'b1;
         if (redirect_valid) begin
            // Everything still in flight belongs to the old path and must be dropped.
            fetch_pc_r    <= {redirect_pc[31:2], 2'b00};
            pcq_head_r    <= '0;
            pcq_tail_r    <= '0;
            buf_head_r    <= '0;
            buf_tail_r    <= '0;
            occupancy_r   <= '0;
            discard_r     <= outstanding_r - CW'(rsp_s);
            outstanding_r <= outstanding_r - CW'(rsp_s);
         end else begin
            if (grant_s) begin
               fetch_pc_r <= fetch_pc_r + 32'd4;
               pcq_tail_r <= ptr_inc(pcq_tail_r);
            end
            if (push_s) begin
               pcq_head_r <= ptr_inc(pcq_head_r);
               buf_tail_r <= ptr_inc(buf_tail_r);
            end
            if (pop_s) buf_head_r <= ptr_inc(buf_head_r);
            if (rsp_s && (discard_r != '0)) discard_r <= discard_r - CW'(1);
            case ({grant_s, rsp_s})
               2'b10:   outstanding_r <= outstanding_r + CW'(1);
               2'b01:   outstanding_r <= outstanding_r - CW'(1);
               default: outstanding_r <= outstanding_r;
            endcase
            case ({push_s, pop_s})
               2'b10:   occupancy_r <= occupancy_r + CW'(1);
               2'b01:   occupancy_r <= occupancy_r - CW'(1);
               default: occupancy_r <= occupancy_r;
            endcase
         end
      end
   end

   // Queue payloads; only read behind a nonzero count, so they carry no reset.
   always_ff @(posedge clk) begin
      if (grant_s) pcq_mem_r[pcq_tail_r] <= fetch_pc_r;
      if (push_s) begin
         buf_pc_r[buf_tail_r]   <= pcq_mem_r[pcq_head_r];
         buf_inst_r[buf_tail_r] <= imem_rdata;
      end
   end

   fetch_unit_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_rvalid (imem_rvalid),
      .outstanding (outstanding_r),
      .occupancy   (occupancy_r)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model checked every cycle, plus
// literal expectations on reset values and on the decode stream after redirects.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0100;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_ready;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc          (if_pc),
      .if_ready       (if_ready)
   );

   typedef struct { logic [31:0] addr; int due; } mreq_t;
   typedef struct { logic [31:0] pc; bit wrong; } fl_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } xfer_t;

   mreq_t       mem_q[$];   // memory side: granted addresses awaiting response
   fl_t         m_fl[$];    // model: in-flight fetches, oldest first
   logic [31:0] m_buf[$];   // model: buffered PCs awaiting decode
   xfer_t       xfer[$];    // every transfer the DUT made to decode
   logic [31:0] m_pc;
   bit          m_run;
   int          cyc;
   int          lat;
   int          vectors;
   int          miscompares;
   int          n0;
   bit          found;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: condition not reached within cycle budget", name);
   endtask

   task automatic model_reset();
      m_fl.delete();
      m_buf.delete();
      mem_q.delete();
      m_pc  = RESET_PC;
      m_run = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_imem_req"}, {31'b0, imem_req}, 32'h0);
      chk({tag, "_imem_addr"}, imem_addr, 32'h0000_0100);
      chk({tag, "_if_valid"}, {31'b0, if_valid}, 32'h0);
      chk({tag, "_if_inst"}, if_inst, 32'h0000_0013);
      chk({tag, "_if_pc"}, if_pc, 32'h0000_0000);
   endtask

   task automatic pin_xfer(input string name, input int idx, input logic [31:0] pc,
                           input logic [31:0] inst);
      if (idx < xfer.size()) begin
         chk({name, "_pc"}, xfer[idx].pc, pc);
         chk({name, "_inst"}, xfer[idx].inst, inst);
      end else begin
         vectors++;
         miscompares++;
         $display("FAIL %s: only %0d transfers seen, need index %0d", name, xfer.size(), idx);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, then advance both at the edge.
   task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] rpc);
      bit          rsp;
      bit          e_req;
      bit          e_valid;
      bit          m_grant;
      bit          dut_grant;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] g_addr;
      imem_gnt       = gnt;
      if_ready       = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      rsp            = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
      imem_rvalid    = rsp;
      imem_rdata     = 32'h0;
      if (rsp) imem_rdata = mem_word(mem_q[0].addr);
      #1;
      e_req   = m_run && !redir && ((m_fl.size() + m_buf.size()) < DEPTH);
      e_valid = (m_buf.size() > 0) && !redir;
      e_pc    = 32'h0;
      e_inst  = NOP;
      if (m_buf.size() > 0) begin
         e_pc   = m_buf[0];
         e_inst = mem_word(m_buf[0]);
      end
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("imem_addr", imem_addr, m_pc);
      chk("if_valid", {31'b0, if_valid}, {31'b0, e_valid});
      chk("if_pc", if_pc, e_pc);
      chk("if_inst", if_inst, e_inst);
      if (if_valid && if_ready) xfer.push_back('{if_pc, if_inst});
      dut_grant = imem_req && imem_gnt;
      g_addr    = imem_addr;
      m_grant   = e_req && gnt;
      @(posedge clk);
      if (rsp) void'(mem_q.pop_front());
      if (dut_grant) mem_q.push_back('{g_addr, cyc + lat});
      if (e_valid && rdy) void'(m_buf.pop_front());
      if (rsp && (m_fl.size() > 0)) begin
         fl_t h;
         h = m_fl.pop_front();
         if (!h.wrong && !redir) m_buf.push_back(h.pc);
      end
      if (redir) begin
         m_buf.delete();
         foreach (m_fl[i]) m_fl[i].wrong = 1'b1;
         m_pc = {rpc[31:2], 2'b00};
      end else if (m_grant) begin
         m_fl.push_back('{m_pc, 1'b0});
         m_pc = m_pc + 32'd4;
      end
      m_run = 1'b1;
      cyc++;
      #1;
   endtask

   initial begin
      vectors        = 0;
      miscompares    = 0;
      cyc            = 0;
      lat            = 1;
      rst_n          = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if_ready       = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("rst");
      rst_n = 1'b1;

      // Streaming with a 1-cycle memory.
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      pin_xfer("t1_x0", 0, 32'h0000_0100, 32'hC0DE_0100);
      pin_xfer("t1_x1", 1, 32'h0000_0104, 32'hC0DE_0104);
      pin_xfer("t1_x2", 2, 32'h0000_0108, 32'hC0DE_0108);

      // Decode backpressure, then grant stall.
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < xfer.size(); i++) chk("seq_pc", xfer[i].pc, RESET_PC + 32'(4 * i));

      // Redirect with two fetches in flight and nothing buffered.
      lat   = 3;
      found = 1'b0;
      n0    = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m_fl.size() == 2 && m_buf.size() == 0 &&
             !(mem_q.size() > 0 && mem_q[0].due <= cyc)) begin
            n0 = xfer.size();
            step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
            found = 1'b1;
         end else begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
         end
      end
      if (!found) bound_fail("t4_setup");
      for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      if (found) pin_xfer("t4_target", n0, 32'h0000_0200, 32'hC0DE_0200);

      // Redirect coinciding with a response and a decode-ready buffered word.
      lat   = 1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (m_buf.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            n0 = xfer.size();
            step(1'b1, 1'b1, 1'b1, 32'h0000_0302);
            found = 1'b1;
         end else begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
         end
      end
      if (!found) bound_fail("t5_setup");
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      if (found) pin_xfer("t5_target", n0, 32'h0000_0300, 32'hC0DE_0300);

      // Asynchronous reset between clock edges.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      #2;
      rst_n          = 1'b0;
      imem_rvalid    = 1'b0;
      imem_gnt       = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check_reset_values("async");
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n0    = xfer.size();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
      pin_xfer("t6_restart", n0, 32'h0000_0100, 32'hC0DE_0100);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
